// File: rtl/cmp_pkg.sv
// Shared constants and FSM encoding for the multi-byte magnitude comparator.
package cmp_pkg;
  localparam int CMP_MAX_BYTES = 8;
  localparam int CMP_IDX_W     = 3;

  typedef enum logic [1:0] {
    CMP_IDLE = 2'd0,
    CMP_RUN  = 2'd1,
    CMP_DONE = 2'd2
  } cmp_state_t;
endpackage

// File: rtl/cmp_sequencer_if.sv
// Request/result bundle between the ALU front end and cmp_sequencer.
// signed_mode exists only when CMP_SIGNED_EN is defined.
interface cmp_sequencer_if #(parameter int NBYTES = 4);
  logic                           start;
  logic [8*NBYTES-1:0]            a;
  logic [8*NBYTES-1:0]            b;
`ifdef CMP_SIGNED_EN
  logic                           signed_mode;
`endif
  logic                           busy;
  logic                           done;
  logic                           gt;
  logic                           lt;
  logic                           eq;
  logic [cmp_pkg::CMP_IDX_W-1:0]  diff_idx;

`ifdef CMP_SIGNED_EN
  modport master (output start, a, b, signed_mode,
                  input  busy, done, gt, lt, eq, diff_idx);
  modport slave  (input  start, a, b, signed_mode,
                  output busy, done, gt, lt, eq, diff_idx);
`else
  modport master (output start, a, b,
                  input  busy, done, gt, lt, eq, diff_idx);
  modport slave  (input  start, a, b,
                  output busy, done, gt, lt, eq, diff_idx);
`endif
endinterface

// File: rtl/byte_cmp.sv
// Combinational 8-bit unsigned greater/less/equal compare stage.
module byte_cmp (
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic       gt,
  output logic       lt,
  output logic       eq
);
  assign gt = (x > y);
  assign lt = (x < y);
  assign eq = (x == y);
endmodule

// File: rtl/cmp_sequencer.sv
// Byte-serial magnitude comparator, MSB first, stops at the first unequal byte.
// Optional two's-complement ordering on the top byte under CMP_SIGNED_EN.
module cmp_sequencer
  import cmp_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  cmp_sequencer_if.slave  bus
);
  localparam int OPW = 8 * CMP_MAX_BYTES;
  localparam logic [CMP_IDX_W-1:0] TOP_IDX = CMP_IDX_W'(NBYTES - 1);

  cmp_state_t           state, state_nxt;
  logic [CMP_IDX_W-1:0] idx;
  logic [OPW-1:0]       a_r, b_r;
  logic                 gt_r, lt_r, eq_r;
  logic [CMP_IDX_W-1:0] diff_r;
  logic [7:0]           x_byte, y_byte;
  logic                 byte_gt, byte_lt, byte_eq;
`ifdef CMP_SIGNED_EN
  logic                 sm_r;
`endif

  // Operands are held zero-extended to the maximum width so a 3-bit idx always selects in range.
  always_comb begin
    x_byte = a_r[{idx, 3'b000} +: 8];
    y_byte = b_r[{idx, 3'b000} +: 8];
`ifdef CMP_SIGNED_EN
    if (sm_r && (idx == TOP_IDX)) begin
      x_byte[7] = ~x_byte[7];
      y_byte[7] = ~y_byte[7];
    end
`endif
  end

  byte_cmp u_byte_cmp (
    .x  (x_byte),
    .y  (y_byte),
    .gt (byte_gt),
    .lt (byte_lt),
    .eq (byte_eq)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      CMP_IDLE: if (bus.start) state_nxt = CMP_RUN;
      CMP_RUN:  if (!byte_eq || (idx == '0)) state_nxt = CMP_DONE;
      CMP_DONE: state_nxt = CMP_IDLE;
      default:  state_nxt = CMP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= CMP_IDLE;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      gt_r   <= 1'b0;
      lt_r   <= 1'b0;
      eq_r   <= 1'b0;
      diff_r <= '0;
`ifdef CMP_SIGNED_EN
      sm_r   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        CMP_IDLE: begin
          if (bus.start) begin
            a_r    <= OPW'(bus.a);
            b_r    <= OPW'(bus.b);
            idx    <= TOP_IDX;
            gt_r   <= 1'b0;
            lt_r   <= 1'b0;
            eq_r   <= 1'b0;
            diff_r <= '0;
`ifdef CMP_SIGNED_EN
            sm_r   <= bus.signed_mode;
`endif
          end
        end
        CMP_RUN: begin
          if (!byte_eq) begin
            gt_r   <= byte_gt;
            lt_r   <= byte_lt;
            diff_r <= idx;
          end else if (idx == '0) begin
            eq_r   <= 1'b1;
            diff_r <= '0;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == CMP_RUN);
  assign bus.done     = (state == CMP_DONE);
  assign bus.gt       = gt_r;
  assign bus.lt       = lt_r;
  assign bus.eq       = eq_r;
  assign bus.diff_idx = diff_r;
endmodule

// File: tb/tb_cmp_sequencer.sv
// Directed plus random checks of cmp_sequencer against a whole-word arithmetic model.
module tb_cmp_sequencer;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  cmp_sequencer_if #(.NBYTES(NB)) bus ();

  cmp_sequencer #(.NBYTES(NB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ordering from whole-word compare; deciding byte = most significant differing byte.
  task automatic model(input logic [31:0] av, input logic [31:0] bv, input logic sm,
                       output logic egt, output logic elt, output logic eeq,
                       output int didx, output int k);
    bit found = 0;
    didx = 0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (!found && (av[i*8 +: 8] != bv[i*8 +: 8])) begin
        didx  = i;
        found = 1;
      end
    end
    eeq = (av == bv);
    if (sm) begin
      egt = ($signed(av) > $signed(bv));
      elt = ($signed(av) < $signed(bv));
    end else begin
      egt = (av > bv);
      elt = (av < bv);
    end
    k = eeq ? NB : NB - didx;
  endtask

  task automatic drive(input logic st, input logic [31:0] av, input logic [31:0] bv, input logic sm);
    bus.start = st;
    bus.a     = av;
    bus.b     = bv;
`ifdef CMP_SIGNED_EN
    bus.signed_mode = sm;
`else
    if (sm) $display("[TB] note: signed_mode request ignored in unsigned build");
`endif
  endtask

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sm,
                        input bit junk, input string tag);
    logic egt, elt, eeq;
    int   didx, k;
    model(av, bv, sm, egt, elt, eeq, didx, k);
    @(negedge clk);
    drive(1'b1, av, bv, sm);
    @(posedge clk);
    #1;
    // While busy, present conflicting operands; with junk=1 start is also held high.
    drive(junk, ~av, ~bv, ~sm);
    for (int c = 1; c <= k + 1; c++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(bus.busy), 32'(c <= k));
      check({tag, "_done"}, 32'(bus.done), 32'(c == k + 1));
      if (c == 1) begin
        check({tag, "_clr"}, {29'd0, bus.gt, bus.lt, bus.eq}, 32'd0);
      end
      if (c == k + 1) begin
        check({tag, "_flags"}, {29'd0, bus.gt, bus.lt, bus.eq}, {29'd0, egt, elt, eeq});
        check({tag, "_idx"}, 32'(bus.diff_idx), 32'(didx));
      end
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    check({tag, "_hold"}, {26'd0, bus.gt, bus.lt, bus.eq, bus.diff_idx},
          {26'd0, egt, elt, eeq, 3'(didx)});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rsm;
    int          j;

    reset_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_out", {26'd0, bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.diff_idx}, 32'd0);
    reset_n = 1'b1;

    run_op(32'h12345678, 32'h12345678, 1'b0, 0, "equal");
    run_op(32'h80000000, 32'h7FFFFFFF, 1'b0, 0, "msb_unsigned");
    run_op(32'h00000001, 32'h00000002, 1'b0, 0, "lsb_lt");
    run_op(32'hFF000000, 32'h00000000, 1'b0, 1, "start_busy");
    run_op(32'h00AB0000, 32'h00AA0000, 1'b0, 1, "byte2_gt");
`ifdef CMP_SIGNED_EN
    run_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 0, "msb_signed");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 0, "signed_neg");
`endif

    // Reset in the middle of an equal-operand compare.
    @(negedge clk);
    drive(1'b1, 32'h12345678, 32'h12345678, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_reset", {26'd0, bus.busy, bus.done, bus.gt, bus.lt, bus.eq, bus.diff_idx}, 32'd0);
    reset_n = 1'b1;
    run_op(32'h12345678, 32'h12345678, 1'b0, 0, "after_reset");

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = ra;
      j  = $urandom_range(0, 5);
      if (j < NB) rb[j*8 +: 8] = 8'($urandom);
      else if (j == NB) rb = $urandom;
`ifdef CMP_SIGNED_EN
      rsm = 1'($urandom_range(0, 1));
`else
      rsm = 1'b0;
`endif
      run_op(ra, rb, rsm, bit'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
